// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the two-channel memory bus controller.
//   CMD_*    : external bus command codes driven on ext_cmd (1xx reserved)
//   state_t  : controller FSM states
package mem_bus_pkg;

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_FETCH = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: bundles the fetch channel, data channel and external bus
// of mem_bus_ctrl.
//   master : controller view (accepts requests, drives the external bus)
//   slave  : client/memory view (issues requests, answers the external bus)
// Parameters: DW data width (multiple of 8), AW address width.
interface mem_bus_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  // fetch channel
  logic            if_req;
  logic            if_rdy;
  logic [AW-1:0]   if_addr;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            if_err;

  // data channel
  logic            d_req;
  logic            d_rdy;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            d_err;

  // external bus
  logic [2:0]      ext_cmd;
  logic [AW-1:0]   ext_addr;
  logic [DW-1:0]   ext_wdata;
  logic [DW/8-1:0] ext_be;
  logic [DW-1:0]   ext_rdata;
  logic            ext_ready;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  ext_rdata, ext_ready,
    output if_rdy, if_rvalid, if_rdata, if_err,
    output d_rdy, d_rvalid, d_rdata, d_err,
    output ext_cmd, ext_addr, ext_wdata, ext_be
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output ext_rdata, ext_ready,
    input  if_rdy, if_rvalid, if_rdata, if_err,
    input  d_rdy, d_rvalid, d_rdata, d_err,
    input  ext_cmd, ext_addr, ext_wdata, ext_be
  );

endinterface

// File: rtl/mem_bus_req_buf.sv
// mem_bus_req_buf: one-entry request buffer.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request strobe, accepted when rdy=1
//   din      : payload captured on acceptance
//   clr      : empties the buffer (only asserted while full)
//   rdy      : buffer empty
//   full     : buffer holds a request
//   q        : stored payload
module mem_bus_req_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic [W-1:0] din,
  input  logic         clr,
  output logic         rdy,
  output logic         full,
  output logic [W-1:0] q
);

  logic         full_r;
  logic [W-1:0] q_r;

  // occupancy flag: set on acceptance, dropped by clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r <= 1'b0;
    end else if (clr) begin
      full_r <= 1'b0;
    end else if (req && !full_r) begin
      full_r <= 1'b1;
    end else begin
      full_r <= full_r;
    end
  end

  // payload register, loaded only when a request is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {W{1'b0}};
    end else if (req && !full_r) begin
      q_r <= din;
    end else begin
      q_r <= q_r;
    end
  end

  assign rdy  = !full_r;
  assign full = full_r;
  assign q    = q_r;

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: two-channel external memory bus controller.
// Instruction fetches (if_*) and loads/stores (d_*) each land in a one-entry
// buffer and are arbitrated round-robin onto a single external bus (ext_*).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_bus_ctrl_if.master (fetch channel, data channel, ext bus)
// Parameters: DW data width, AW address width, TIMEOUT abort limit.
// Optional feature: define MEM_BUS_CTRL_TIMEOUT_EN to abort transfers whose
// ext_ready does not arrive within TIMEOUT wait cycles (if_err/d_err report
// it). Without the macro the controller waits indefinitely and the err
// outputs are constant 0.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_ctrl_if.master bus
);

  localparam int BW  = DW / 8;
  localparam int DPW = 1 + AW + DW + BW;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  // buffer interface
  logic            if_rdy_s, if_full_s, d_rdy_s, d_full_s;
  logic [AW-1:0]   if_q_s;
  logic [DPW-1:0]  d_din_s, d_q_s, d_pl_s;

  // request currently presented to the arbiter
  logic [AW-1:0]   if_addr_s, d_addr_s;
  logic            d_we_s;
  logic [DW-1:0]   d_wdata_s;
  logic [BW-1:0]   d_be_s;

  logic            if_acc_s, d_acc_s, if_pend_s, d_pend_s, pick_data_s;
  logic            done_s, abort_s;

  state_t          state_r, state_nxt;
  logic            last_data_r, last_data_nxt;
  logic [2:0]      cmd_r, cmd_nxt;
  logic [AW-1:0]   addr_r, addr_nxt;
  logic [DW-1:0]   wdata_r, wdata_nxt;
  logic [BW-1:0]   be_r, be_nxt;
  logic            if_rvalid_r, if_rvalid_nxt, d_rvalid_r, d_rvalid_nxt;
  logic [DW-1:0]   if_rdata_r, if_rdata_nxt, d_rdata_r, d_rdata_nxt;

  assign d_din_s = {bus.d_we, bus.d_addr, bus.d_wdata, bus.d_be};

  // The buffer is emptied one cycle after completion so that rdy rises on
  // the cycle following the rvalid pulse.
  mem_bus_req_buf #(.W(AW)) u_if_buf (
    .clk  (clk),
    .rst  (rst),
    .req  (bus.if_req),
    .din  (bus.if_addr),
    .clr  (if_rvalid_r),
    .rdy  (if_rdy_s),
    .full (if_full_s),
    .q    (if_q_s)
  );

  mem_bus_req_buf #(.W(DPW)) u_d_buf (
    .clk  (clk),
    .rst  (rst),
    .req  (bus.d_req),
    .din  (d_din_s),
    .clr  (d_rvalid_r),
    .rdy  (d_rdy_s),
    .full (d_full_s),
    .q    (d_q_s)
  );

  assign if_acc_s = bus.if_req && if_rdy_s;
  assign d_acc_s  = bus.d_req && d_rdy_s;

  // A request being accepted this cycle is forwarded straight to the FSM so
  // ext_cmd appears the cycle after acceptance. A full buffer whose rvalid is
  // currently pulsing is already served and waits only to be cleared.
  assign if_pend_s = (if_full_s && !if_rvalid_r) || if_acc_s;
  assign d_pend_s  = (d_full_s && !d_rvalid_r) || d_acc_s;

  assign if_addr_s = if_full_s ? if_q_s : bus.if_addr;
  assign d_pl_s    = d_full_s ? d_q_s : d_din_s;
  assign {d_we_s, d_addr_s, d_wdata_s, d_be_s} = d_pl_s;

  // round-robin: data wins unless it was the last channel served
  assign pick_data_s = d_pend_s && (!if_pend_s || !last_data_r);

  assign done_s = (state_r != ST_IDLE) && bus.ext_ready;

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;
  logic          if_err_r, d_err_r;

  // wait-cycle counter, restarted whenever the bus is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r == ST_IDLE) begin
      cnt_r <= {CW{1'b0}};
    end else if (!bus.ext_ready) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // abort on the wait cycle that brings the count to TIMEOUT; a ready on
  // that same cycle still completes normally
  assign abort_s = (state_r != ST_IDLE) && !bus.ext_ready && (cnt_r == CNT_LAST);

  // error flags pulse together with the matching rvalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_err_r <= 1'b0;
      d_err_r  <= 1'b0;
    end else begin
      if_err_r <= abort_s && (state_r == ST_FETCH);
      d_err_r  <= abort_s && ((state_r == ST_READ) || (state_r == ST_WRITE));
    end
  end

  assign bus.if_err = if_err_r;
  assign bus.d_err  = d_err_r;
`else
  assign abort_s    = 1'b0;
  assign bus.if_err = 1'b0;
  assign bus.d_err  = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_data_s) begin
          state_nxt = d_we_s ? ST_WRITE : ST_READ;
        end else if (if_pend_s) begin
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FETCH, ST_READ, ST_WRITE: begin
        if (done_s || abort_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = state_r;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered bus and response outputs
  always_comb begin
    cmd_nxt       = cmd_r;
    addr_nxt      = addr_r;
    wdata_nxt     = wdata_r;
    be_nxt        = be_r;
    last_data_nxt = last_data_r;
    if_rvalid_nxt = 1'b0;
    d_rvalid_nxt  = 1'b0;
    if_rdata_nxt  = if_rdata_r;
    d_rdata_nxt   = d_rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_data_s) begin
          cmd_nxt       = d_we_s ? CMD_WRITE : CMD_READ;
          addr_nxt      = d_addr_s;
          wdata_nxt     = d_we_s ? d_wdata_s : {DW{1'b0}};
          be_nxt        = d_we_s ? d_be_s : {BW{1'b1}};
          last_data_nxt = 1'b1;
        end else if (if_pend_s) begin
          cmd_nxt       = CMD_FETCH;
          addr_nxt      = if_addr_s;
          wdata_nxt     = {DW{1'b0}};
          be_nxt        = {BW{1'b1}};
          last_data_nxt = 1'b0;
        end else begin
          cmd_nxt       = CMD_IDLE;
        end
      end
      ST_FETCH, ST_READ, ST_WRITE: begin
        if (done_s || abort_s) begin
          cmd_nxt   = CMD_IDLE;
          addr_nxt  = {AW{1'b0}};
          wdata_nxt = {DW{1'b0}};
          be_nxt    = {BW{1'b0}};
          if (state_r == ST_FETCH) begin
            if_rvalid_nxt = 1'b1;
            if_rdata_nxt  = abort_s ? {DW{1'b0}} : bus.ext_rdata;
          end else begin
            d_rvalid_nxt  = 1'b1;
            d_rdata_nxt   = (abort_s || (state_r == ST_WRITE)) ? {DW{1'b0}} : bus.ext_rdata;
          end
        end else begin
          cmd_nxt = cmd_r;
        end
      end
      default: begin
        cmd_nxt   = CMD_IDLE;
        addr_nxt  = {AW{1'b0}};
        wdata_nxt = {DW{1'b0}};
        be_nxt    = {BW{1'b0}};
      end
    endcase
  end

  // registered bus outputs, responses and arbitration history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_r       <= CMD_IDLE;
      addr_r      <= {AW{1'b0}};
      wdata_r     <= {DW{1'b0}};
      be_r        <= {BW{1'b0}};
      last_data_r <= 1'b0;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if_rdata_r  <= {DW{1'b0}};
      d_rdata_r   <= {DW{1'b0}};
    end else begin
      cmd_r       <= cmd_nxt;
      addr_r      <= addr_nxt;
      wdata_r     <= wdata_nxt;
      be_r        <= be_nxt;
      last_data_r <= last_data_nxt;
      if_rvalid_r <= if_rvalid_nxt;
      d_rvalid_r  <= d_rvalid_nxt;
      if_rdata_r  <= if_rdata_nxt;
      d_rdata_r   <= d_rdata_nxt;
    end
  end

  assign bus.if_rdy    = if_rdy_s;
  assign bus.d_rdy     = d_rdy_s;
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.d_rvalid  = d_rvalid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.ext_cmd   = cmd_r;
  assign bus.ext_addr  = addr_r;
  assign bus.ext_wdata = wdata_r;
  assign bus.ext_be    = be_r;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed self-checking bench for mem_bus_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_mem_bus_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_bus_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  mem_bus_ctrl #(.DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0; bus.d_be = 4'h0;
    bus.ext_rdata = 32'h0; bus.ext_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.ext_cmd !== 3'b000) begin n_err++; $display("FAIL rst_cmd: got %h expected %h", bus.ext_cmd, 3'b000); end
    n_cmp++; if (bus.ext_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h expected %h", bus.ext_addr, 32'h0); end
    n_cmp++; if (bus.ext_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h expected %h", bus.ext_wdata, 32'h0); end
    n_cmp++; if (bus.ext_be !== 4'h0) begin n_err++; $display("FAIL rst_be: got %h expected %h", bus.ext_be, 4'h0); end
    n_cmp++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin n_err++; $display("FAIL rst_rdata: got %h expected %h", {bus.if_rdata, bus.d_rdata}, 64'h0); end
    n_cmp++; if ({bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b expected %b", {bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err}, 4'b0000); end
    n_cmp++; if ({bus.if_rdy, bus.d_rdy} !== 2'b11) begin n_err++; $display("FAIL rst_rdy: got %b expected %b", {bus.if_rdy, bus.d_rdy}, 2'b11); end
  endtask

  task automatic test_single_fetch();
    bus.ext_ready = 1'b1; bus.ext_rdata = 32'hDEADBEEF;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();                                       // N+1
    bus.if_req = 1'b0;
    n_cmp++; if (bus.ext_cmd !== 3'b001) begin n_err++; $display("FAIL fetch_cmd: got %h expected %h", bus.ext_cmd, 3'b001); end
    n_cmp++; if (bus.ext_addr !== 32'h100) begin n_err++; $display("FAIL fetch_addr: got %h expected %h", bus.ext_addr, 32'h100); end
    n_cmp++; if (bus.ext_be !== 4'hF) begin n_err++; $display("FAIL fetch_be: got %h expected %h", bus.ext_be, 4'hF); end
    n_cmp++; if ({bus.if_rdy, bus.if_rvalid} !== 2'b00) begin n_err++; $display("FAIL fetch_busy: got %b expected %b", {bus.if_rdy, bus.if_rvalid}, 2'b00); end
    tick();                                       // N+2
    n_cmp++; if (bus.if_rvalid !== 1'b1) begin n_err++; $display("FAIL fetch_rvalid: got %b expected %b", bus.if_rvalid, 1'b1); end
    n_cmp++; if (bus.if_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL fetch_rdata: got %h expected %h", bus.if_rdata, 32'hDEADBEEF); end
    n_cmp++; if ({bus.if_err, bus.if_rdy, bus.ext_cmd} !== 5'b00000) begin n_err++; $display("FAIL fetch_done: got %b expected %b", {bus.if_err, bus.if_rdy, bus.ext_cmd}, 5'b00000); end
    tick();                                       // N+3
    n_cmp++; if ({bus.if_rvalid, bus.if_rdy} !== 2'b01) begin n_err++; $display("FAIL fetch_rdy_back: got %b expected %b", {bus.if_rvalid, bus.if_rdy}, 2'b01); end
    n_cmp++; if (bus.if_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL fetch_hold: got %h expected %h", bus.if_rdata, 32'hDEADBEEF); end
  endtask

  task automatic test_arbitration();
    do_reset();
    bus.ext_ready = 1'b1; bus.ext_rdata = 32'hAAAA0001;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    tick();                                       // N+1: read wins
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    n_cmp++; if (bus.ext_cmd !== 3'b010) begin n_err++; $display("FAIL arb_first_cmd: got %h expected %h", bus.ext_cmd, 3'b010); end
    n_cmp++; if (bus.ext_addr !== 32'h300) begin n_err++; $display("FAIL arb_first_addr: got %h expected %h", bus.ext_addr, 32'h300); end
    n_cmp++; if (bus.if_rdy !== 1'b0) begin n_err++; $display("FAIL arb_if_held: got %b expected %b", bus.if_rdy, 1'b0); end
    tick();                                       // N+2: idle gap
    bus.ext_rdata = 32'hBBBB0002;
    n_cmp++; if (bus.ext_cmd !== 3'b000) begin n_err++; $display("FAIL arb_gap: got %h expected %h", bus.ext_cmd, 3'b000); end
    n_cmp++; if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'hAAAA0001}) begin n_err++; $display("FAIL arb_read_resp: got %h expected %h", {bus.d_rvalid, bus.d_rdata}, {1'b1, 32'hAAAA0001}); end
    tick();                                       // N+3: fetch
    n_cmp++; if (bus.ext_cmd !== 3'b001) begin n_err++; $display("FAIL arb_second_cmd: got %h expected %h", bus.ext_cmd, 3'b001); end
    n_cmp++; if (bus.ext_addr !== 32'h200) begin n_err++; $display("FAIL arb_second_addr: got %h expected %h", bus.ext_addr, 32'h200); end
    tick();                                       // N+4
    n_cmp++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'hBBBB0002}) begin n_err++; $display("FAIL arb_fetch_resp: got %h expected %h", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'hBBBB0002}); end
    n_cmp++; if (bus.d_rdata !== 32'hAAAA0001) begin n_err++; $display("FAIL arb_d_hold: got %h expected %h", bus.d_rdata, 32'hAAAA0001); end
    tick();
  endtask

  task automatic test_write_wait();
    bus.ext_ready = 1'b0; bus.ext_rdata = 32'hFFFFFFFF;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h400;
    bus.d_wdata = 32'h12345678; bus.d_be = 4'b0011;
    tick();                                       // N+1
    bus.d_req = 1'b0; bus.d_wdata = 32'h0; bus.d_be = 4'h0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({bus.ext_cmd, bus.ext_addr, bus.ext_wdata, bus.ext_be, bus.d_rvalid} !== {3'b011, 32'h400, 32'h12345678, 4'b0011, 1'b0})
        begin n_err++; $display("FAIL write_stable[%0d]: got %h expected %h", i, {bus.ext_cmd, bus.ext_addr, bus.ext_wdata, bus.ext_be, bus.d_rvalid}, {3'b011, 32'h400, 32'h12345678, 4'b0011, 1'b0}); end
      if (i == 4) bus.ext_ready = 1'b1;
      tick();
    end
    n_cmp++; if ({bus.d_rvalid, bus.d_err} !== 2'b10) begin n_err++; $display("FAIL write_resp: got %b expected %b", {bus.d_rvalid, bus.d_err}, 2'b10); end
    n_cmp++; if (bus.d_rdata !== 32'h0) begin n_err++; $display("FAIL write_rdata: got %h expected %h", bus.d_rdata, 32'h0); end
    tick();
    n_cmp++; if (bus.d_rdy !== 1'b1) begin n_err++; $display("FAIL write_rdy: got %b expected %b", bus.d_rdy, 1'b1); end
  endtask

  task automatic test_reset_mid_read();
    bus.ext_ready = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
    tick();
    bus.d_req = 1'b0;
    n_cmp++; if (bus.ext_cmd !== 3'b010) begin n_err++; $display("FAIL rmid_cmd: got %h expected %h", bus.ext_cmd, 3'b010); end
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.ext_cmd !== 3'b000) begin n_err++; $display("FAIL rmid_async_cmd: got %h expected %h", bus.ext_cmd, 3'b000); end
    n_cmp++; if ({bus.d_rdy, bus.d_rvalid} !== 2'b10) begin n_err++; $display("FAIL rmid_async_rdy: got %b expected %b", {bus.d_rdy, bus.d_rvalid}, 2'b10); end
    tick();
    rst = 1'b0; bus.ext_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({bus.d_rvalid, bus.ext_cmd} !== 4'b0000) begin n_err++; $display("FAIL rmid_dropped[%0d]: got %b expected %b", i, {bus.d_rvalid, bus.ext_cmd}, 4'b0000); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.ext_ready = 1'b1; bus.ext_rdata = 32'hCAFEF00D;
    bus.if_req = 1'b1; bus.if_addr = 32'h580;
    tick(); bus.if_req = 1'b0;
    tick(); tick();
    bus.ext_ready = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    tick();                                       // N+1
    bus.if_req = 1'b0;
    n_cmp++; if (bus.ext_cmd !== 3'b001) begin n_err++; $display("FAIL tmo_cmd: got %h expected %h", bus.ext_cmd, 3'b001); end
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      n_cmp++; if (bus.if_rvalid !== 1'b0) begin n_err++; $display("FAIL tmo_early[%0d]: got %b expected %b", i, bus.if_rvalid, 1'b0); end
    end
    tick();
    n_cmp++; if ({bus.if_rvalid, bus.if_err} !== 2'b11) begin n_err++; $display("FAIL tmo_abort: got %b expected %b", {bus.if_rvalid, bus.if_err}, 2'b11); end
    n_cmp++; if (bus.if_rdata !== 32'h0) begin n_err++; $display("FAIL tmo_rdata: got %h expected %h", bus.if_rdata, 32'h0); end
    n_cmp++; if (bus.ext_cmd !== 3'b000) begin n_err++; $display("FAIL tmo_idle: got %h expected %h", bus.ext_cmd, 3'b000); end
`else
    for (int i = 0; i < TMO + 4; i++) begin
      tick();
      n_cmp++; if ({bus.ext_cmd, bus.if_rvalid, bus.if_err} !== 5'b00100) begin n_err++; $display("FAIL wait_forever[%0d]: got %b expected %b", i, {bus.ext_cmd, bus.if_rvalid, bus.if_err}, 5'b00100); end
    end
    bus.ext_ready = 1'b1; bus.ext_rdata = 32'h0BADF00D;
    tick();
    n_cmp++; if ({bus.if_rvalid, bus.if_err, bus.if_rdata} !== {2'b10, 32'h0BADF00D}) begin n_err++; $display("FAIL wait_done: got %h expected %h", {bus.if_rvalid, bus.if_err, bus.if_rdata}, {2'b10, 32'h0BADF00D}); end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] prev;
    logic [2:0] exp_cmd;
    logic [31:0] exp_addr;
    int seen;
    do_reset();
    bus.ext_ready = 1'b1; bus.ext_rdata = 32'h5555AAAA;
    bus.if_req = 1'b1; bus.if_addr = 32'h700;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800;
    prev = 3'b000;
    seen = 0;
    for (int c = 0; c < 200 && seen < 20; c++) begin
      tick();
      if (bus.ext_cmd !== 3'b000 && prev === 3'b000) begin
        exp_cmd  = (seen % 2 == 0) ? 3'b010 : 3'b001;
        exp_addr = (seen % 2 == 0) ? 32'h800 : 32'h700;
        n_cmp++; if ({bus.ext_cmd, bus.ext_addr} !== {exp_cmd, exp_addr}) begin n_err++; $display("FAIL b2b_xfer[%0d]: got %h expected %h", seen, {bus.ext_cmd, bus.ext_addr}, {exp_cmd, exp_addr}); end
        seen++;
      end
      prev = bus.ext_cmd;
    end
    n_cmp++; if (seen != 20) begin n_err++; $display("FAIL b2b_count: got %0d expected %0d", seen, 20); end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_arbitration();
    test_write_wait();
    test_reset_mid_read();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
